// File: rtl/safe_pkg.sv
// Shared types and key codes for the digital-safe controller.
// State encoding is visible on the state output, so values are fixed.
package safe_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PROG    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  function automatic logic key_is_digit(input logic [3:0] k);
    return (k < 4'd10);
  endfunction

endpackage

// File: rtl/safe_digit_buffer.sv
// Purpose: PW_LEN x BCD entry buffer with saturating counter and password compare.
// Latency: push/clear take effect at the next edge; match and full are combinational on registers.
// Backpressure: none; digits pushed while full are silently dropped.
module safe_digit_buffer #(
  parameter int PW_LEN = 6,
  localparam int CW = $clog2(PW_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic [3:0]            i_digit,
  input  logic [4*PW_LEN-1:0]   i_pw,
  output logic [CW-1:0]         o_cnt_nxt,
  output logic                  o_full,
  output logic                  o_match,
  output logic [4*PW_LEN-1:0]   o_buf
);

  localparam logic [CW-1:0] C_FULL = CW'(PW_LEN);

  logic [4*PW_LEN-1:0] r_buf;
  logic [CW-1:0]       r_cnt;
  logic                w_take;

  assign o_full  = (r_cnt == C_FULL);
  assign w_take  = i_push && !o_full;
  assign o_match = o_full && (r_buf == i_pw);
  assign o_buf   = r_buf;

  always_comb begin
    o_cnt_nxt = r_cnt;
    if (i_clr) begin
      o_cnt_nxt = '0;
    end else if (w_take) begin
      o_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // Digit 0 lands in the most-significant nibble to line up with the pw vector.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      for (int i = 0; i < PW_LEN; i++) begin
        if (r_cnt == CW'(i)) begin
          r_buf[4*(PW_LEN-1-i) +: 4] <= i_digit;
        end
      end
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/safe_lock_ctrl.sv
// Purpose: keypad-driven safe FSM with password check, reprogramming and failed-attempt lockout.
// Latency: all outputs registered; '#' at edge n shows CHECK after n and the verdict after n+1.
// Backpressure: none; key events not meaningful in the current state are dropped.
module safe_lock_ctrl
  import safe_pkg::*;
#(
  parameter int                  PW_LEN         = 6,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW     = 24'h123456,
  localparam int                 FW             = $clog2(MAX_FAIL + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              initialize,
  output logic [PW_LEN-1:0] digit_led,
  output logic [2:0]        state,
  output logic              unlocked,
  output logic              locked_out,
  output logic [FW-1:0]     fail_count
);

  localparam int            CW           = $clog2(PW_LEN + 1);
  localparam int            TW           = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [FW-1:0] C_MAX_FAIL   = FW'(MAX_FAIL);
  localparam logic [TW-1:0] C_TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);

  state_t              r_state;
  logic [4*PW_LEN-1:0] r_pw;
  logic [FW-1:0]       r_fail;
  logic [TW-1:0]       r_timer;
  logic [PW_LEN-1:0]   r_digit_led;
  logic                r_unlocked;
  logic                r_locked_out;

  state_t              w_state_nxt;
  logic [FW-1:0]       w_fail_nxt;
  logic [FW-1:0]       w_fail_inc;
  logic [TW-1:0]       w_timer_nxt;
  logic                w_clr;
  logic                w_push;
  logic                w_pw_we;
  logic                w_star;
  logic                w_hash;
  logic                w_digit;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_full;
  logic                w_match;
  logic [4*PW_LEN-1:0] w_buf;
  logic [PW_LEN-1:0]   w_led_nxt;

  assign w_star     = key_valid && (key_code == KEY_STAR);
  assign w_hash     = key_valid && (key_code == KEY_HASH);
  assign w_digit    = key_valid && key_is_digit(key_code);
  assign w_fail_inc = r_fail + FW'(1);

  safe_digit_buffer #(
    .PW_LEN (PW_LEN)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_push    (w_push),
    .i_digit   (key_code),
    .i_pw      (r_pw),
    .o_cnt_nxt (w_cnt_nxt),
    .o_full    (w_full),
    .o_match   (w_match),
    .o_buf     (w_buf)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail;
    w_timer_nxt = r_timer;
    w_clr       = 1'b0;
    w_push      = 1'b0;
    w_pw_we     = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (w_star) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (w_star) begin
          w_clr = 1'b1;
        end else if (w_hash) begin
          w_state_nxt = ST_CHECK;
        end else if (w_digit) begin
          w_push = 1'b1;
        end
      end
      ST_CHECK: begin
        w_clr = 1'b1;
        if (w_match) begin
          w_fail_nxt  = '0;
          w_state_nxt = ST_OPEN;
        end else if (w_fail_inc != C_MAX_FAIL) begin
          w_fail_nxt  = w_fail_inc;
          w_state_nxt = ST_LOCKED;
        end else begin
          w_fail_nxt  = C_MAX_FAIL;
          w_timer_nxt = C_TIMER_LOAD;
          w_state_nxt = ST_LOCKOUT;
        end
      end
      ST_OPEN: begin
        if (w_star) begin
          w_state_nxt = ST_LOCKED;
        end else if (initialize) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_PROG;
        end
      end
      ST_PROG: begin
        if (w_star) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_OPEN;
        end else if (w_hash) begin
          w_clr = 1'b1;
          if (w_full) begin
            w_pw_we     = 1'b1;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_OPEN;
          end
        end else if (w_digit) begin
          w_push = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == '0) begin
          w_fail_nxt  = '0;
          w_state_nxt = ST_LOCKED;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: w_state_nxt = ST_LOCKED;
    endcase
  end

  // LED thermometer is built from the next count so it lines up with the registered state.
  always_comb begin
    w_led_nxt = '0;
    if ((w_state_nxt == ST_ENTRY) || (w_state_nxt == ST_PROG)) begin
      for (int i = 0; i < PW_LEN; i++) begin
        w_led_nxt[i] = (CW'(i) < w_cnt_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_LOCKED;
      r_pw         <= DEFAULT_PW;
      r_fail       <= '0;
      r_timer      <= '0;
      r_digit_led  <= '0;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fail       <= w_fail_nxt;
      r_timer      <= w_timer_nxt;
      r_digit_led  <= w_led_nxt;
      r_unlocked   <= (w_state_nxt == ST_OPEN);
      r_locked_out <= (w_state_nxt == ST_LOCKOUT);
      if (w_pw_we) begin
        r_pw <= w_buf;
      end
    end
  end

  assign state      = r_state;
  assign digit_led  = r_digit_led;
  assign unlocked   = r_unlocked;
  assign locked_out = r_locked_out;
  assign fail_count = r_fail;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Bench for safe_lock_ctrl: vector table, directed corner sequences, then random traffic
// compared every cycle against a digit-queue reference model.
module tb_safe_lock_ctrl;

  localparam int          PW_LEN   = 6;
  localparam int          MAX_FAIL = 3;
  localparam int          LO_CYC   = 1000;
  localparam logic [23:0] DEF_PW   = 24'h123456;

  localparam int S_LOCKED = 0, S_ENTRY = 1, S_CHECK = 2, S_OPEN = 3, S_PROG = 4, S_LOCKOUT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       initialize = 1'b0;
  logic [5:0] digit_led;
  logic [2:0] state;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_count;

  int n_cmp = 0;
  int n_bad = 0;

  safe_lock_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .initialize (initialize),
    .digit_led  (digit_led),
    .state      (state),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  // Reference model: entry and password kept as digit queues, lockout as remaining dwell.
  int m_st;
  int m_buf[$];
  int m_pw[$];
  int m_fail;
  int m_left;

  function automatic bit same_digits();
    if (m_buf.size() != m_pw.size()) return 1'b0;
    foreach (m_buf[i]) if (m_buf[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit kv, input int kc, input bit init, input bit rst);
    bit star, hash, dig;
    logic [23:0] d;
    star = kv && (kc == 10);
    hash = kv && (kc == 11);
    dig  = kv && (kc <= 9);
    if (rst) begin
      m_st = S_LOCKED; m_fail = 0; m_left = 0;
      m_buf.delete(); m_pw.delete();
      d = DEF_PW;
      for (int i = 0; i < PW_LEN; i++) m_pw.push_back(int'((d >> (4*(PW_LEN-1-i))) & 24'hF));
      return;
    end
    case (m_st)
      S_LOCKED: if (star) begin m_buf.delete(); m_st = S_ENTRY; end
      S_ENTRY: begin
        if (star) m_buf.delete();
        else if (hash) m_st = S_CHECK;
        else if (dig && m_buf.size() < PW_LEN) m_buf.push_back(kc);
      end
      S_CHECK: begin
        if (m_buf.size() == PW_LEN && same_digits()) begin
          m_st = S_OPEN; m_fail = 0;
        end else if (m_fail + 1 >= MAX_FAIL) begin
          m_fail = MAX_FAIL; m_st = S_LOCKOUT; m_left = LO_CYC;
        end else begin
          m_fail++; m_st = S_LOCKED;
        end
        m_buf.delete();
      end
      S_OPEN: begin
        if (star) m_st = S_LOCKED;
        else if (init) begin m_buf.delete(); m_st = S_PROG; end
      end
      S_PROG: begin
        if (star) begin m_buf.delete(); m_st = S_OPEN; end
        else if (hash) begin
          if (m_buf.size() == PW_LEN) begin m_pw = m_buf; m_st = S_LOCKED; end
          else m_st = S_OPEN;
          m_buf.delete();
        end else if (dig && m_buf.size() < PW_LEN) m_buf.push_back(kc);
      end
      S_LOCKOUT: begin
        m_left--;
        if (m_left == 0) begin m_st = S_LOCKED; m_fail = 0; end
      end
      default: m_st = S_LOCKED;
    endcase
  endtask

  function automatic void check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endfunction

  task automatic cyc(input bit kv, input logic [3:0] kc, input bit init, input bit rst);
    int exp_led;
    key_valid = kv; key_code = kc; initialize = init; reset = rst;
    @(posedge clk);
    model_step(kv, int'(kc), init, rst);
    #1;
    exp_led = (m_st == S_ENTRY || m_st == S_PROG) ? ((1 << m_buf.size()) - 1) : 0;
    check("mdl_state", int'(state), m_st);
    check("mdl_led", int'(digit_led), exp_led);
    check("mdl_unlocked", int'(unlocked), int'(m_st == S_OPEN));
    check("mdl_locked_out", int'(locked_out), int'(m_st == S_LOCKOUT));
    check("mdl_fail", int'(fail_count), m_fail);
    key_valid = 1'b0; reset = 1'b0; initialize = 1'b0;
  endtask

  task automatic key(input int k);
    cyc(1'b1, 4'(k), 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic enter_pw(input int d0, input int d1, input int d2, input int d3,
                          input int d4, input int d5);
    key(10); key(d0); key(d1); key(d2); key(d3); key(d4); key(d5); key(11); idle();
  endtask

  task automatic expect_st(input string nm, input int st, input int fl);
    check({nm, "_state"}, int'(state), st);
    check({nm, "_fail"}, int'(fail_count), fl);
  endtask

  typedef struct {
    bit kv; logic [3:0] kc; bit init;
    logic [2:0] st; logic [5:0] led; bit unl; bit lo; logic [1:0] fl;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit kv, input logic [3:0] kc, input logic [2:0] st,
                              input logic [5:0] led, input bit unl, input bit lo,
                              input logic [1:0] fl);
    vec_t v;
    v.kv = kv; v.kc = kc; v.init = 1'b0;
    v.st = st; v.led = led; v.unl = unl; v.lo = lo; v.fl = fl;
    tbl.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_lo;
    int pwc[$];

    // correct entry, relock, ignored keys, short attempt, wrong attempt, third failure
    add(1,10, 1,6'h00,0,0,0); add(1,1, 1,6'h01,0,0,0); add(1,2, 1,6'h03,0,0,0);
    add(1,3, 1,6'h07,0,0,0);  add(1,4, 1,6'h0f,0,0,0); add(1,5, 1,6'h1f,0,0,0);
    add(1,6, 1,6'h3f,0,0,0);  add(1,11,2,6'h00,0,0,0); add(0,0, 3,6'h00,1,0,0);
    add(1,13,3,6'h00,1,0,0);  add(1,10,0,6'h00,0,0,0); add(1,13,0,6'h00,0,0,0);
    add(1,5, 0,6'h00,0,0,0);  add(1,11,0,6'h00,0,0,0); add(1,10,1,6'h00,0,0,0);
    add(1,13,1,6'h00,0,0,0);  add(1,1, 1,6'h01,0,0,0); add(1,2, 1,6'h03,0,0,0);
    add(1,3, 1,6'h07,0,0,0);  add(1,11,2,6'h00,0,0,0); add(1,10,0,6'h00,0,0,1);
    add(1,10,1,6'h00,0,0,1);  add(1,6, 1,6'h01,0,0,1); add(1,5, 1,6'h03,0,0,1);
    add(1,4, 1,6'h07,0,0,1);  add(1,3, 1,6'h0f,0,0,1); add(1,2, 1,6'h1f,0,0,1);
    add(1,1, 1,6'h3f,0,0,1);  add(1,11,2,6'h00,0,0,1); add(0,0, 0,6'h00,0,0,2);
    add(1,10,1,6'h00,0,0,2);  add(1,11,2,6'h00,0,0,2); add(0,0, 5,6'h00,0,1,3);

    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, 4'd10, 1'b1, 1'b1);
    check("rst_state", int'(state), 0);
    check("rst_led", int'(digit_led), 0);
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_locked_out", int'(locked_out), 0);
    check("rst_fail", int'(fail_count), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].kv, tbl[i].kc, tbl[i].init, 1'b0);
      check($sformatf("tbl%0d_state", i), int'(state), int'(tbl[i].st));
      check($sformatf("tbl%0d_led", i), int'(digit_led), int'(tbl[i].led));
      check($sformatf("tbl%0d_unl", i), int'(unlocked), int'(tbl[i].unl));
      check($sformatf("tbl%0d_lo", i), int'(locked_out), int'(tbl[i].lo));
      check($sformatf("tbl%0d_fail", i), int'(fail_count), int'(tbl[i].fl));
    end

    // lockout dwell with key strobes thrown at it
    n_lo = 1;
    for (int i = 0; i < 1100; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      if (state == 3'd5) n_lo++;
      else break;
    end
    check("lockout_dwell", n_lo, LO_CYC);
    expect_st("after_lockout", 0, 0);

    // reprogram, then old password must fail
    enter_pw(1,2,3,4,5,6);
    expect_st("open_default", 3, 0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    expect_st("enter_prog", 4, 0);
    key(9); key(8); key(7); key(13);
    check("prog_led3", int'(digit_led), 7);
    key(6); key(5); key(4); key(11);
    expect_st("prog_commit", 0, 0);
    enter_pw(9,8,7,6,5,4);
    expect_st("open_newpw", 3, 0);
    cyc(1'b1, 4'd10, 1'b1, 1'b0);
    expect_st("star_beats_init", 0, 0);
    enter_pw(1,2,3,4,5,6);
    expect_st("old_pw_rejected", 0, 1);

    // eight digits: last two dropped, first six compared
    key(10); key(9); key(8); key(7); key(6); key(5); key(4); key(3); key(2);
    check("sat_led", int'(digit_led), 6'h3f);
    key(11); idle();
    expect_st("eight_digits", 3, 0);

    // short commit and abort leave the password alone
    cyc(1'b0, 4'd0, 1'b1, 1'b0); key(1); key(2); key(11);
    expect_st("prog_short", 3, 0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0); key(10);
    expect_st("prog_abort", 3, 0);
    key(10);
    enter_pw(9,8,7,6,5,4);
    expect_st("pw_kept", 3, 0);

    // reset in PROG reverts the password
    cyc(1'b0, 4'd0, 1'b1, 1'b0); key(1); key(1); key(1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    expect_st("reset_in_prog", 0, 0);
    check("reset_in_prog_led", int'(digit_led), 0);
    check("reset_in_prog_unl", int'(unlocked), 0);
    enter_pw(1,2,3,4,5,6);
    expect_st("pw_reverted", 3, 0);

    // random traffic against the model
    for (int it = 0; it < 4000; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
      end else if (r < 9) begin
        pwc = m_pw;
        key(10);
        foreach (pwc[j]) key(pwc[j]);
        key(11); idle();
      end else begin
        cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
